// File: rtl/operand_fetch_writeback_if.sv
// Instruction handshake, ALU operand/result bus, writeback observation and
// debug read port of the operand fetch / writeback stage.
interface operand_fetch_writeback_if #(
    parameter int WIDTH = 16
);
    logic             in_valid;
    logic [WIDTH-1:0] in_instr;
    logic             in_ready;
    logic [WIDTH-1:0] alu_instr;
    logic [WIDTH-1:0] alu_rddata;
    logic [WIDTH-1:0] alu_rsdata;
    logic [WIDTH-1:0] alu_rmdata;
    logic [WIDTH-1:0] alu_n;
    logic [WIDTH-1:0] alu_result;
    logic             retire;
    logic             wb_en;
    logic [2:0]       wb_addr;
    logic [WIDTH-1:0] wb_data;
    logic [2:0]       dbg_addr;
    logic [WIDTH-1:0] dbg_data;

    modport slave (
        input  in_valid, in_instr, alu_result, dbg_addr,
        output in_ready, alu_instr, alu_rddata, alu_rsdata, alu_rmdata, alu_n,
               retire, wb_en, wb_addr, wb_data, dbg_data
    );

    modport master (
        output in_valid, in_instr, alu_result, dbg_addr,
        input  in_ready, alu_instr, alu_rddata, alu_rsdata, alu_rmdata, alu_n,
               retire, wb_en, wb_addr, wb_data, dbg_data
    );
endinterface

// File: rtl/operand_fetch_writeback.sv
// Operand fetch / writeback stage around a combinational ALU. Owns the 8x16
// register file and runs one instruction at a time: IDLE -> OPER -> WB.
module operand_fetch_writeback #(
    parameter int NREGS  = 8,
    parameter int WIDTH  = 16,
    parameter int NWIDTH = 5
) (
    input  logic                      clk,
    input  logic                      rst_n,
    operand_fetch_writeback_if.slave  bus
);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_OPER = 2'd1,
        S_WB   = 2'd2
    } state_t;

    state_t           state_q, state_d;
    logic [WIDTH-1:0] regs [NREGS];

    logic [WIDTH-1:0] alu_instr_p0;
    logic [WIDTH-1:0] alu_rddata_p0;
    logic [WIDTH-1:0] alu_rsdata_p0;
    logic [WIDTH-1:0] alu_rmdata_p0;
    logic [WIDTH-1:0] alu_n_p0;

    logic             wb_en_p1;
    logic [2:0]       wb_addr_p1;
    logic [WIDTH-1:0] wb_data_p1;

    logic             accept;

    function automatic logic is_writing(input logic [3:0] opcode);
        logic w;
        case (opcode)
            4'b1000, 4'b1001, 4'b1010, 4'b1011,
            4'b1100, 4'b1101, 4'b1110, 4'b1111,
            4'b0110, 4'b0111: w = 1'b1;
            default:          w = 1'b0;
        endcase
        return w;
    endfunction

    assign accept = (state_q == S_IDLE) && bus.in_valid;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state_q <= S_IDLE;
        else        state_q <= state_d;
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            S_IDLE:  if (bus.in_valid) state_d = S_OPER;
            S_OPER:  state_d = S_WB;
            S_WB:    state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase
    end

    // Fetch: decode the accepted word and read all three source operands.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            alu_instr_p0  <= '0;
            alu_rddata_p0 <= '0;
            alu_rsdata_p0 <= '0;
            alu_rmdata_p0 <= '0;
            alu_n_p0      <= '0;
        end else if (accept) begin
            alu_instr_p0  <= bus.in_instr;
            alu_rddata_p0 <= regs[bus.in_instr[10:8]];
            alu_rsdata_p0 <= regs[bus.in_instr[7:5]];
            alu_rmdata_p0 <= regs[bus.in_instr[4:2]];
            alu_n_p0      <= {{(WIDTH-NWIDTH){1'b0}}, bus.in_instr[NWIDTH-1:0]};
        end
    end

    // Capture: the ALU output has settled by the end of OPER.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wb_en_p1   <= 1'b0;
            wb_addr_p1 <= '0;
            wb_data_p1 <= '0;
        end else if (state_q == S_OPER) begin
            wb_en_p1   <= is_writing(alu_instr_p0[15:12]);
            wb_addr_p1 <= alu_instr_p0[10:8];
            wb_data_p1 <= bus.alu_result;
        end else if (state_q == S_WB) begin
            wb_en_p1   <= 1'b0;
        end
    end

    // Commit: the write lands on the edge that ends WB, before the next fetch edge.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < NREGS; i++) regs[i] <= '0;
        end else if (state_q == S_WB && wb_en_p1) begin
            regs[wb_addr_p1] <= wb_data_p1;
        end
    end

    assign bus.in_ready   = (state_q == S_IDLE);
    assign bus.retire     = (state_q == S_WB);
    assign bus.alu_instr  = alu_instr_p0;
    assign bus.alu_rddata = alu_rddata_p0;
    assign bus.alu_rsdata = alu_rsdata_p0;
    assign bus.alu_rmdata = alu_rmdata_p0;
    assign bus.alu_n      = alu_n_p0;
    assign bus.wb_en      = wb_en_p1;
    assign bus.wb_addr    = wb_addr_p1;
    assign bus.wb_data    = wb_data_p1;
    assign bus.dbg_data   = regs[bus.dbg_addr];

endmodule

// File: tb/tb_operand_fetch_writeback.sv
// Randomized bench for operand_fetch_writeback: a behavioural ALU drives
// alu_result and a register-array model predicts every observable value.
module tb_operand_fetch_writeback;

    logic clk;
    logic rst_n;

    operand_fetch_writeback_if #(.WIDTH(16)) ifc ();

    operand_fetch_writeback #(.NREGS(8), .WIDTH(16), .NWIDTH(5)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (ifc)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int n_cmp = 0;
    int n_err = 0;
    logic [15:0] mdl [8];

    function automatic logic [15:0] alu_fn(input logic [15:0] ins, rd, rs, rm, n);
        case (ins[15:12])
            4'h7:    return n;
            4'h8:    return rs + rm;
            4'h9:    return rs + n;
            4'hA:    return rs - rm;
            4'hB:    return rs - n;
            4'h6:    return rs << n[3:0];
            default: return (rd ^ rm) + {12'h0, ins[15:12]} + 16'h1234;
        endcase
    endfunction

    function automatic logic writes(input logic [15:0] ins);
        return ins[15:12] inside {[4'h8:4'hF], 4'h6, 4'h7};
    endfunction

    function automatic logic [15:0] predict(input logic [15:0] ins);
        return alu_fn(ins, mdl[ins[10:8]], mdl[ins[7:5]], mdl[ins[4:2]], {11'b0, ins[4:0]});
    endfunction

    always_comb ifc.alu_result = alu_fn(ifc.alu_instr, ifc.alu_rddata, ifc.alu_rsdata,
                                        ifc.alu_rmdata, ifc.alu_n);

    task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp);
        n_cmp++;
        if (obs !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%04h, expected 0x%04h (t=%0t)", tag, obs, exp, $time);
        end
    endtask

    task automatic dbg_sweep(input string tag);
        for (int i = 0; i < 8; i++) begin
            ifc.dbg_addr = 3'(i);
            #1;
            chk(tag, ifc.dbg_data, mdl[i]);
        end
    endtask

    // Full three-cycle transaction with checks in OPER and WB.
    task automatic issue(input logic [15:0] ins);
        logic [15:0] exp_res;
        @(negedge clk);
        chk("in_ready_idle", {15'b0, ifc.in_ready}, 16'd1);
        ifc.in_valid = 1'b1;
        ifc.in_instr = ins;
        exp_res = predict(ins);
        @(posedge clk);
        #1;
        ifc.in_valid = 1'b0;
        ifc.in_instr = 16'($urandom);
        @(negedge clk);
        chk("oper_in_ready", {15'b0, ifc.in_ready}, 16'd0);
        chk("oper_retire",   {15'b0, ifc.retire},   16'd0);
        chk("alu_instr",  ifc.alu_instr,  ins);
        chk("alu_rddata", ifc.alu_rddata, mdl[ins[10:8]]);
        chk("alu_rsdata", ifc.alu_rsdata, mdl[ins[7:5]]);
        chk("alu_rmdata", ifc.alu_rmdata, mdl[ins[4:2]]);
        chk("alu_n",      ifc.alu_n,      {11'b0, ins[4:0]});
        @(negedge clk);
        chk("wb_retire",  {15'b0, ifc.retire}, 16'd1);
        chk("wb_en",      {15'b0, ifc.wb_en},  {15'b0, writes(ins)});
        chk("wb_addr",    {13'b0, ifc.wb_addr}, {13'b0, ins[10:8]});
        chk("wb_data",    ifc.wb_data, exp_res);
        if (writes(ins)) mdl[ins[10:8]] = exp_res;
    endtask

    logic [15:0] q [4];
    logic [15:0] b2b_exp;
    int          retires;
    int          idx;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, t=%0t", $time);
        $fatal(1, "watchdog");
    end

    initial begin
        rst_n        = 1'b0;
        ifc.in_valid = 1'b0;
        ifc.in_instr = 16'h0;
        ifc.dbg_addr = 3'd0;
        for (int i = 0; i < 8; i++) mdl[i] = 16'h0;

        repeat (3) @(posedge clk);
        @(negedge clk);
        chk("rst_retire", {15'b0, ifc.retire}, 16'd0);
        chk("rst_wb_en",  {15'b0, ifc.wb_en},  16'd0);
        chk("rst_wb_data", ifc.wb_data, 16'd0);
        chk("rst_alu_instr", ifc.alu_instr, 16'd0);
        rst_n = 1'b1;
        @(negedge clk);
        chk("rst_in_ready", {15'b0, ifc.in_ready}, 16'd1);
        dbg_sweep("rst_dbg");

        // Directed: MOV I, then ADD R and a dependent read of the result.
        issue(16'h7105);
        @(posedge clk); #1;
        ifc.dbg_addr = 3'd1; #1;
        chk("mov_r1", ifc.dbg_data, 16'd5);
        issue(16'h7203);
        issue(16'h8328);
        @(posedge clk); #1;
        ifc.dbg_addr = 3'd3; #1;
        chk("add_r3", ifc.dbg_data, 16'd8);
        issue(16'h8060);

        // NOP opcode retires but leaves the register file alone.
        issue(16'h0123);
        dbg_sweep("nop_dbg");

        // Back-to-back valid: accept every third cycle.
        for (int i = 0; i < 4; i++)
            q[i] = {4'h8 + 4'($urandom_range(0, 7)), 12'($urandom)};
        retires = 0;
        idx     = 0;
        b2b_exp = 16'h0;
        @(negedge clk);
        ifc.in_valid = 1'b1;
        ifc.in_instr = q[0];
        for (int k = 0; k < 12; k++) begin
            if (k != 0) @(negedge clk);
            chk("b2b_in_ready", {15'b0, ifc.in_ready}, {15'b0, 1'((k % 3) == 0)});
            chk("b2b_retire",   {15'b0, ifc.retire},   {15'b0, 1'((k % 3) == 2)});
            if (ifc.retire) retires++;
            if (k % 3 == 0) b2b_exp = predict(q[idx]);
            if (k % 3 == 2) begin
                chk("b2b_wb_data", ifc.wb_data, b2b_exp);
                mdl[q[idx][10:8]] = b2b_exp;
                idx++;
            end
            @(posedge clk); #1;
            if (k % 3 == 0) begin
                if (idx < 3) ifc.in_instr = q[idx + 1];
                else         ifc.in_valid = 1'b0;
            end
        end
        chk("b2b_retires", 16'(retires), 16'd4);
        dbg_sweep("b2b_dbg");

        // Random traffic over all opcodes.
        for (int t = 0; t < 40; t++) begin
            issue(16'($urandom));
            @(posedge clk); #1;
            ifc.dbg_addr = 3'($urandom_range(0, 7)); #1;
            chk("rand_dbg", ifc.dbg_data, mdl[ifc.dbg_addr]);
        end

        // Reset during OPER discards the instruction.
        @(negedge clk);
        ifc.in_valid = 1'b1;
        ifc.in_instr = 16'h7407;
        @(posedge clk); #1;
        ifc.in_valid = 1'b0;
        @(negedge clk);
        rst_n = 1'b0;
        #1;
        for (int i = 0; i < 8; i++) mdl[i] = 16'h0;
        chk("midrst_retire",   {15'b0, ifc.retire},   16'd0);
        chk("midrst_in_ready", {15'b0, ifc.in_ready}, 16'd1);
        chk("midrst_wb_en",    {15'b0, ifc.wb_en},    16'd0);
        @(negedge clk);
        rst_n = 1'b1;
        for (int k = 0; k < 3; k++) begin
            @(negedge clk);
            chk("midrst_no_retire", {15'b0, ifc.retire},   16'd0);
            chk("midrst_idle",      {15'b0, ifc.in_ready}, 16'd1);
        end
        ifc.dbg_addr = 3'd4; #1;
        chk("midrst_r4", ifc.dbg_data, 16'd0);
        issue(16'h7407);
        @(posedge clk); #1;
        ifc.dbg_addr = 3'd4; #1;
        chk("post_rst_r4", ifc.dbg_data, 16'd7);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
